// File: rtl/uart_dbg_frame_parser.sv
// UART debug frame parser: turns READ/WRITE/EXEC/challenge byte frames into byte-memory
// accesses and exec pulses. Optional inter-byte timeout is enabled by UART_DBG_TIMEOUT_EN.
module uart_dbg_frame_parser #(
    parameter int unsigned TimeoutCycles = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        exec_valid_o,
    output logic [63:0] exec_addr_o,
    output logic        busy_o
);
    localparam logic [7:0] CodeRead  = 8'h11;
    localparam logic [7:0] CodeWrite = 8'h12;
    localparam logic [7:0] CodeExec  = 8'h13;
    localparam logic [7:0] CodeAck   = 8'h06;
    localparam logic [7:0] CodeEot   = 8'h04;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0, ST_ADDR  = 4'd1, ST_LEN   = 4'd2, ST_ACK  = 4'd3,
        ST_WDATA = 4'd4, ST_WMEM  = 4'd5, ST_RREQ  = 4'd6, ST_RWAIT = 4'd7,
        ST_RTX   = 4'd8, ST_EOT   = 4'd9, ST_EXEC  = 4'd10
    } state_t;

    state_t      state_r, next_s, state_s;
    logic [7:0]  cmd_r;
    logic [2:0]  cnt_r;
    logic [63:0] addr_r, len_r;
    logic [7:0]  wdata_r, tx_data_s;
    logic        rx_ready_r, tx_valid_r, mem_req_r, mem_we_r, exec_valid_r, busy_r;
    logic [7:0]  tx_data_r;
    logic        rx_fire_s, tx_fire_s, timeout_s;

    assign rx_fire_s = rx_valid_i && rx_ready_r;
    assign tx_fire_s = tx_valid_r && tx_ready_i;

`ifdef UART_DBG_TIMEOUT_EN
    logic [31:0] to_cnt_r;
    logic        wait_s;
    assign wait_s    = (state_r == ST_ADDR) || (state_r == ST_LEN) || (state_r == ST_WDATA);
    assign timeout_s = wait_s && !rx_fire_s && (to_cnt_r == 32'(TimeoutCycles - 32'd1));

    // Inter-byte idle counter, cleared on every accepted byte and outside the waiting states
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_r <= 32'd0;
        end else if (!wait_s || rx_fire_s || timeout_s) begin
            to_cnt_r <= 32'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic of the frame FSM
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    if (rx_data_i == CodeAck) begin
                        next_s = ST_ACK;
                    end else if ((rx_data_i == CodeRead) || (rx_data_i == CodeWrite) ||
                                 (rx_data_i == CodeExec)) begin
                        next_s = ST_ADDR;
                    end else begin
                        next_s = ST_IDLE;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ADDR:  next_s = (rx_fire_s && cnt_r == 3'd7) ?
                               ((cmd_r == CodeExec) ? ST_ACK : ST_LEN) : ST_ADDR;
            ST_LEN:   next_s = (rx_fire_s && cnt_r == 3'd7) ? ST_ACK : ST_LEN;
            ST_ACK: begin
                // The latched command also remembers a bare challenge (cmd == ACK)
                if (!tx_fire_s) begin
                    next_s = ST_ACK;
                end else if (cmd_r == CodeExec) begin
                    next_s = ST_EXEC;
                end else if (cmd_r == CodeAck) begin
                    next_s = ST_IDLE;
                end else if (len_r == 64'd0) begin
                    next_s = ST_EOT;
                end else if (cmd_r == CodeRead) begin
                    next_s = ST_RREQ;
                end else begin
                    next_s = ST_WDATA;
                end
            end
            ST_WDATA: next_s = rx_fire_s ? ST_WMEM : ST_WDATA;
            ST_WMEM:  next_s = mem_gnt_i ? ((len_r == 64'd1) ? ST_EOT : ST_WDATA) : ST_WMEM;
            ST_RREQ:  next_s = mem_gnt_i ? ST_RWAIT : ST_RREQ;
            ST_RWAIT: next_s = mem_rvalid_i ? ST_RTX : ST_RWAIT;
            ST_RTX:   next_s = tx_fire_s ? ((len_r == 64'd1) ? ST_EOT : ST_RREQ) : ST_RTX;
            ST_EOT:   next_s = tx_fire_s ? ST_IDLE : ST_EOT;
            ST_EXEC:  next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    assign state_s = timeout_s ? ST_IDLE : next_s;

    // Transmit byte for the upcoming state; read data is captured straight from the bus
    always_comb begin
        tx_data_s = 8'h00;
        case (state_s)
            ST_ACK:  tx_data_s = CodeAck;
            ST_EOT:  tx_data_s = CodeEot;
            ST_RTX:  tx_data_s = (state_r == ST_RWAIT) ? mem_rdata_i : tx_data_r;
            default: tx_data_s = 8'h00;
        endcase
    end

    // State register and outputs registered as a decode of the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            rx_ready_r   <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            exec_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            rx_ready_r   <= (state_s == ST_IDLE) || (state_s == ST_ADDR) ||
                            (state_s == ST_LEN)  || (state_s == ST_WDATA);
            tx_valid_r   <= (state_s == ST_ACK) || (state_s == ST_RTX) || (state_s == ST_EOT);
            tx_data_r    <= tx_data_s;
            mem_req_r    <= (state_s == ST_WMEM) || (state_s == ST_RREQ);
            mem_we_r     <= (state_s == ST_WMEM);
            exec_valid_r <= (state_s == ST_EXEC);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // Frame datapath: command, byte counter, little-endian address/length shift-in, write data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_r   <= 8'h00;
            cnt_r   <= 3'd0;
            addr_r  <= 64'd0;
            len_r   <= 64'd0;
            wdata_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_fire_s) begin
                        cmd_r <= rx_data_i;
                        cnt_r <= 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (rx_fire_s) begin
                        addr_r <= {rx_data_i, addr_r[63:8]};
                        cnt_r  <= cnt_r + 3'd1;
                    end
                end
                ST_LEN: begin
                    if (rx_fire_s) begin
                        len_r <= {rx_data_i, len_r[63:8]};
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_WDATA: begin
                    if (rx_fire_s) begin
                        wdata_r <= rx_data_i;
                    end
                end
                ST_WMEM: begin
                    if (mem_gnt_i) begin
                        addr_r <= addr_r + 64'd1;
                        len_r  <= len_r - 64'd1;
                    end
                end
                ST_RTX: begin
                    if (tx_fire_s) begin
                        addr_r <= addr_r + 64'd1;
                        len_r  <= len_r - 64'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign rx_ready_o   = rx_ready_r;
    assign tx_valid_o   = tx_valid_r;
    assign tx_data_o    = tx_data_r;
    assign mem_req_o    = mem_req_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = addr_r;
    assign mem_wdata_o  = wdata_r;
    assign exec_valid_o = exec_valid_r;
    assign exec_addr_o  = addr_r;
    assign busy_o       = busy_r;
endmodule

// File: tb/tb_uart_dbg_frame_parser.sv
// Self-checking bench for uart_dbg_frame_parser: directed frame table, reset abort,
// optional timeout scenario and randomized frames against a transaction-level model.
module tb_uart_dbg_frame_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid, tx_ready, mem_gnt, mem_rvalid;
    logic [7:0]  rx_data, mem_rdata;
    logic        rx_ready_o, tx_valid_o, mem_req_o, mem_we_o, exec_valid_o, busy_o;
    logic [7:0]  tx_data_o, mem_wdata_o;
    logic [63:0] mem_addr_o, exec_addr_o;

    uart_dbg_frame_parser #(.TimeoutCycles(50)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .exec_valid_o(exec_valid_o), .exec_addr_o(exec_addr_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observed traffic
    logic [7:0]  tx_q[$];
    logic [63:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [63:0] exec_q[$];
    int          rd_reqs = 0, exec_wide = 0, overlap = 0;
    logic        exec_prev = 1'b0;

    // Memory seen by the bus responder and the model's own copy
    logic [7:0]  bus_mem[logic [63:0]];
    logic [7:0]  ref_mem[logic [63:0]];

    function automatic logic [7:0] dflt(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Bus responder, TX sink and exec monitor, all driven/sampled on the falling edge
    logic       pend = 1'b0;
    int         dly = 0;
    logic [7:0] rd_val = 8'h00;
    always @(negedge clk) begin
        logic g, r;
        if (rst) begin
            pend = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; tx_ready = 1'b0; exec_prev = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = rd_val; pend = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (mem_req_o && pend) overlap++;
            g = ($urandom_range(0, 2) != 0);
            if (mem_req_o && g) begin
                if (mem_we_o) begin
                    wr_addr_q.push_back(mem_addr_o);
                    wr_data_q.push_back(mem_wdata_o);
                    bus_mem[mem_addr_o] = mem_wdata_o;
                end else begin
                    rd_reqs++;
                    pend = 1'b1;
                    dly = $urandom_range(0, 3);
                    rd_val = bus_mem.exists(mem_addr_o) ? bus_mem[mem_addr_o] : dflt(mem_addr_o);
                end
            end
            mem_gnt = g;
            r = ($urandom_range(0, 3) != 0);
            if (tx_valid_o && r) tx_q.push_back(tx_data_o);
            tx_ready = r;
            if (exec_valid_o) begin
                exec_q.push_back(exec_addr_o);
                if (exec_prev) exec_wide++;
            end
            exec_prev = exec_valid_o;
        end
    end

    task automatic clear_obs();
        tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); exec_q.delete();
        rd_reqs = 0; exec_wide = 0; overlap = 0;
    endtask

    // Offer one byte (called on a falling edge); returns on the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready_o && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("rx_accept_timeout", 64'(k), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ctrl"}, {58'd0, rx_ready_o, tx_valid_o, mem_req_o, mem_we_o, exec_valid_o, busy_o}, 64'd0);
        chk({tag, " tx_data"}, {56'd0, tx_data_o}, 64'd0);
        chk({tag, " mem_addr"}, mem_addr_o, 64'd0);
        chk({tag, " mem_wdata"}, {56'd0, mem_wdata_o}, 64'd0);
        chk({tag, " exec_addr"}, exec_addr_o, 64'd0);
    endtask

    // Drive one frame and compare the observed traffic with the frame-level model
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [63:0] addr,
                             input logic [63:0] len, input logic [31:0] dat, input logic [8:0] junk);
        logic [7:0]  etx[$];
        logic [63:0] ewa[$];
        logic [7:0]  ewd[$];
        logic [63:0] eexec[$];
        int erd = 0;
        int n = int'(len);
        int k = 0;
        etx.push_back(8'h06);
        if (cmd == 8'h12) begin
            for (int i = 0; i < n; i++) begin
                ewa.push_back(addr + 64'(i));
                ewd.push_back(dat[8*i +: 8]);
                ref_mem[addr + 64'(i)] = dat[8*i +: 8];
            end
            etx.push_back(8'h04);
        end else if (cmd == 8'h11) begin
            for (int i = 0; i < n; i++) etx.push_back(ref_rd(addr + 64'(i)));
            erd = n;
            etx.push_back(8'h04);
        end else if (cmd == 8'h13) begin
            eexec.push_back(addr);
        end
        clear_obs();
        if (junk[8]) send_byte(junk[7:0]);
        send_byte(cmd);
        if (cmd != 8'h06) begin
            for (int i = 0; i < 8; i++) send_byte(addr[8*i +: 8]);
            if (cmd != 8'h13) for (int i = 0; i < 8; i++) send_byte(len[8*i +: 8]);
        end
        chk({tag, " ack_latency"}, {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, 8'h06});
        if (cmd == 8'h12) for (int i = 0; i < n; i++) send_byte(dat[8*i +: 8]);
        while (busy_o && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " busy_low"}, {63'd0, busy_o}, 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, " tx_n"}, 64'(tx_q.size()), 64'(etx.size()));
        for (int i = 0; i < etx.size() && i < tx_q.size(); i++)
            chk($sformatf("%s tx[%0d]", tag, i), {56'd0, tx_q[i]}, {56'd0, etx[i]});
        chk({tag, " wr_n"}, 64'(wr_addr_q.size()), 64'(ewa.size()));
        for (int i = 0; i < ewa.size() && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, i), wr_addr_q[i], ewa[i]);
            chk($sformatf("%s wr_data[%0d]", tag, i), {56'd0, wr_data_q[i]}, {56'd0, ewd[i]});
        end
        chk({tag, " rd_reqs"}, 64'(rd_reqs), 64'(erd));
        chk({tag, " exec_n"}, 64'(exec_q.size()), 64'(eexec.size()));
        if (eexec.size() == 1 && exec_q.size() == 1) chk({tag, " exec_addr"}, exec_q[0], eexec[0]);
        chk({tag, " exec_width"}, 64'(exec_wide), 64'd0);
        chk({tag, " one_outstanding"}, 64'(overlap), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [63:0] addr;
        logic [63:0] len;
        logic [31:0] dat;
        int          ntx;
        logic [31:0] tx;
        int          nwr;
        int          nrd;
        int          nexec;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00; tx_ready = 1'b0;
        vecs[0] = '{"challenge", 8'h06, 64'h0, 64'd0, 32'h0, 1, 32'h00000006, 0, 0, 0};
        vecs[1] = '{"write3", 8'h12, 64'h8000_0000, 64'd3, 32'h00CCBBAA, 2, 32'h00000406, 3, 0, 0};
        vecs[2] = '{"read2", 8'h11, 64'h1000, 64'd2, 32'h0, 4, 32'h04A55A06, 0, 2, 0};
        vecs[3] = '{"exec", 8'h13, 64'h7800_0000, 64'd0, 32'h0, 1, 32'h00000006, 0, 0, 1};
        vecs[4] = '{"write0", 8'h12, 64'h55, 64'd0, 32'h0, 2, 32'h00000406, 0, 0, 0};
        vecs[5] = '{"write_wrap", 8'h12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 32'h00002211, 2, 32'h00000406, 2, 0, 0};
        bus_mem[64'h1000] = 8'h5A; bus_mem[64'h1001] = 8'hA5;
        ref_mem[64'h1000] = 8'h5A; ref_mem[64'h1001] = 8'hA5;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            logic [31:0] txw;
            run_frame(vecs[v].name, vecs[v].cmd, vecs[v].addr, vecs[v].len, vecs[v].dat, 9'h000);
            txw = vecs[v].tx;
            chk({vecs[v].name, " tbl_tx_n"}, 64'(tx_q.size()), 64'(vecs[v].ntx));
            for (int i = 0; i < vecs[v].ntx && i < tx_q.size(); i++)
                chk($sformatf("%s tbl_tx[%0d]", vecs[v].name, i), {56'd0, tx_q[i]}, {56'd0, txw[8*i +: 8]});
            chk({vecs[v].name, " tbl_wr_n"}, 64'(wr_addr_q.size()), 64'(vecs[v].nwr));
            chk({vecs[v].name, " tbl_rd_n"}, 64'(rd_reqs), 64'(vecs[v].nrd));
            chk({vecs[v].name, " tbl_exec_n"}, 64'(exec_q.size()), 64'(vecs[v].nexec));
        end
        chk("wrap addr1", (wr_addr_q.size() == 2) ? wr_addr_q[1] : 64'hDEAD, 64'h0);

        // Reset in the middle of an address phase
        clear_obs();
        send_byte(8'h12);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst no_tx", 64'(tx_q.size()), 64'd0);
        run_frame("post_rst_chal", 8'h06, 64'h0, 64'd0, 32'h0, 9'h000);

`ifdef UART_DBG_TIMEOUT_EN
        begin
            int k = 0;
            clear_obs();
            send_byte(8'h11);
            for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
            while (busy_o && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("timeout cycles_in_range", {63'd0, (k >= 48 && k <= 52)}, 64'd1);
            chk("timeout no_tx", 64'(tx_q.size()), 64'd0);
            run_frame("post_timeout_chal", 8'h06, 64'h0, 64'd0, 32'h0, 9'h000);
        end
`endif

        for (int f = 0; f < 30; f++) begin
            logic [7:0]  cmd, jb;
            logic [63:0] addr;
            logic [8:0]  junk;
            int sel = $urandom_range(0, 3);
            cmd  = (sel == 0) ? 8'h11 : (sel == 1) ? 8'h12 : (sel == 2) ? 8'h13 : 8'h06;
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
            jb = 8'($urandom);
            if (jb == 8'h06 || jb == 8'h11 || jb == 8'h12 || jb == 8'h13) jb = 8'h55;
            junk = {($urandom_range(0, 2) == 0), jb};
            run_frame($sformatf("rnd%0d", f), cmd, addr, 64'($urandom_range(0, 4)), $urandom, junk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_dbg_frame_parser.md
UART_DBG_FRAME_PARSER -- requirements
Module: uart_dbg_frame_parser

Interface
REQ-001 Parameter: TimeoutCycles, default 100000, inter-byte timeout in clk_i cycles (used only with UART_DBG_TIMEOUT_EN).
REQ-002 Port: clk_i  in  1  sole clock; all logic is on its rising edge.
REQ-003 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-004 Port: rx_valid_i / rx_data_i / rx_ready_o  in/in/out  1/8/1  received-byte stream from UART RX.
REQ-005 Port: tx_valid_o / tx_data_o / tx_ready_i  out/out/in  1/8/1  byte stream to UART TX.
REQ-006 Port: mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1/1/64/8  byte memory request.
REQ-007 Port: mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1/1/8  grant, read-response valid, read data.
REQ-008 Port: exec_valid_o / exec_addr_o  out  1/64  one-cycle exec pulse with entry address.
REQ-009 Port: busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Byte codes: READ 0x11, WRITE 0x12, EXEC 0x13, ACK 0x06, EOT 0x04.
REQ-011 Handshakes: a byte transfers on valid&&ready; tx_valid_o/tx_data_o stay stable until accepted; mem_req_o/addr/we/wdata stay stable until mem_gnt_i.
REQ-012 FSM states: IDLE, ADDR, LEN, ACK, WDATA, WMEM, RREQ, RWAIT, RTX, EOT, EXEC.
REQ-013 IDLE, rx byte 0x06: challenge; go to ACK, send 0x06, return to IDLE.
REQ-014 IDLE, rx 0x11/0x12/0x13: latch the command, clear the byte counter, go to ADDR; any other byte is consumed and dropped.
REQ-015 ADDR: collect 8 bytes little-endian into addr; then EXEC goes to ACK, READ/WRITE go to LEN.
REQ-016 LEN: collect 8 bytes little-endian into len, then go to ACK.
REQ-017 ACK: send 0x06; then EXEC goes to EXEC, len==0 goes to EOT, READ goes to RREQ, WRITE goes to WDATA.
REQ-018 WDATA: accept one byte, go to WMEM; WMEM: issue write (we=1) at addr; on grant addr+=1, len-=1; len==0 goes to EOT, else back to WDATA.
REQ-019 RREQ: issue read at addr; on grant go to RWAIT. RWAIT: capture mem_rdata_i on mem_rvalid_i, go to RTX. RTX: send the byte, addr+=1, len-=1; then EOT or RREQ.
REQ-020 One memory request is outstanding at most; the next request is never issued before the previous rvalid (read) or grant (write).
REQ-021 EOT: send 0x04, go to IDLE. EXEC: pulse exec_valid_o for 1 cycle with exec_addr_o=addr, go to IDLE.
REQ-022 Address arithmetic is modulo 2^64: 0xFFFF_FFFF_FFFF_FFFF+1 wraps to 0 with no error.
REQ-023 rx_ready_o is high only in IDLE, ADDR, LEN and WDATA; tx_valid_o is high only in ACK, RTX and EOT.
REQ-024 Latency: the ACK byte appears on tx_valid_o in the cycle after the last address/length byte is accepted.
REQ-025 A len of 2^64-1 is legal; the counter decrements without overflow checks.

Reset
REQ-026 While rst_i is asserted, the FSM is IDLE and every output is 0: rx_ready_o, tx_valid_o, tx_data_o, mem_*_o, exec_*_o and busy_o.
REQ-027 rst_i asserted mid-frame aborts the frame immediately, including any pending memory request; no EOT is sent; the first byte after reset release is parsed from IDLE.

Configuration
REQ-028 Macro UART_DBG_TIMEOUT_EN defined: in ADDR, LEN or WDATA, if no rx byte arrives for TimeoutCycles consecutive cycles, the FSM returns to IDLE silently; the counter restarts on every accepted byte.
REQ-029 Without UART_DBG_TIMEOUT_EN: no timeout counter exists and the FSM waits indefinitely for rx bytes.

Verification
REQ-030 rx 0x06 in IDLE -> tx emits exactly 0x06, busy_o returns to 0.
REQ-031 WRITE, addr 0x8000_0000, len 3, data AA BB CC -> tx 0x06; writes 0x8000_0000=AA, 0x8000_0001=BB, 0x8000_0002=CC; then tx 0x04.
REQ-032 READ, addr 0x1000, len 2, memory returns 5A,A5 -> tx sequence 06 5A A5 04; exactly 2 mem_req_o grants.
REQ-033 EXEC, addr 0x7800_0000 -> tx 0x06, then a single-cycle exec_valid_o with exec_addr_o=0x7800_0000.
REQ-034 WRITE, len 0 -> tx 06 04 and no mem_req_o; separately, rst_i pulsed after 4 address bytes -> all outputs 0, and a following 0x06 challenge is answered with 0x06.
REQ-035 With UART_DBG_TIMEOUT_EN and TimeoutCycles=50: READ plus 3 address bytes, then idle for 50 cycles -> busy_o falls to 0 and no tx byte is emitted.
